// File: rtl/fsm_pattern_transmitter.sv
// Serial pattern transmitter: shifts a captured pattern word out MSB first,
// repeated s_reps times with GAP idle cycles between copies.
module fsm_pattern_transmitter #(
   parameter int   PAT_W    = 4,
   parameter int   CNT_W    = 8,
   parameter int   GAP      = 1,
   parameter logic IDLE_BIT = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [PAT_W-1:0] s_data,
   input  logic [CNT_W-1:0] s_reps,
   output logic             tx_bit,
   output logic             tx_valid,
   output logic             busy,
   output logic             done
);

   localparam int BIT_CNT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam int GAP_CNT_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(PAT_W - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_t;

   state_t               r_state;
   logic [PAT_W-1:0]     r_pat;
   logic [PAT_W-1:0]     r_shift;
   logic [BIT_CNT_W-1:0] r_bit_cnt;
   logic [CNT_W-1:0]     r_reps;
   logic [GAP_CNT_W-1:0] r_gap_cnt;
   logic                 r_tx_bit;
   logic                 r_tx_valid;
   logic                 r_busy;
   logic                 r_done;

   state_t               w_state_nxt;
   logic [PAT_W-1:0]     w_pat_nxt;
   logic [PAT_W-1:0]     w_shift_nxt;
   logic [BIT_CNT_W-1:0] w_bit_cnt_nxt;
   logic [CNT_W-1:0]     w_reps_nxt;
   logic [GAP_CNT_W-1:0] w_gap_cnt_nxt;
   logic                 w_done_nxt;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      w_state_nxt   = r_state;
      w_pat_nxt     = r_pat;
      w_shift_nxt   = r_shift;
      w_bit_cnt_nxt = r_bit_cnt;
      w_reps_nxt    = r_reps;
      w_gap_cnt_nxt = r_gap_cnt;
      w_done_nxt    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (s_valid) begin
               w_pat_nxt     = s_data;
               w_reps_nxt    = s_reps;
               w_bit_cnt_nxt = '0;
               w_gap_cnt_nxt = '0;
               if (s_reps != '0) begin
                  w_state_nxt = ST_SHIFT;
                  w_shift_nxt = s_data;
               end else begin
                  w_done_nxt = 1'b1;
               end
            end
         end

         ST_SHIFT: begin
            w_shift_nxt   = {r_shift[PAT_W-2:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
            if (r_bit_cnt == BIT_LAST) begin
               w_bit_cnt_nxt = '0;
               if (r_reps > CNT_W'(1)) begin
                  w_reps_nxt = r_reps - CNT_W'(1);
                  if (GAP > 0) begin
                     w_state_nxt   = ST_GAP;
                     w_gap_cnt_nxt = '0;
                  end else begin
                     w_shift_nxt = r_pat;
                  end
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end

         ST_GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
               w_state_nxt   = ST_SHIFT;
               w_shift_nxt   = r_pat;
               w_gap_cnt_nxt = '0;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + GAP_CNT_W'(1);
            end
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with the state they describe.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
      if (reset) begin
         r_state    <= ST_IDLE;
         r_pat      <= '0;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_reps     <= '0;
         r_gap_cnt  <= '0;
         r_tx_bit   <= IDLE_BIT;
         r_tx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pat      <= w_pat_nxt;
         r_shift    <= w_shift_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_reps     <= w_reps_nxt;
         r_gap_cnt  <= w_gap_cnt_nxt;
         r_tx_bit   <= (w_state_nxt == ST_SHIFT) ? w_shift_nxt[PAT_W-1] : IDLE_BIT;
         r_tx_valid <= (w_state_nxt == ST_SHIFT);
         r_busy     <= (w_state_nxt != ST_IDLE);
         r_done     <= w_done_nxt;
      end
   end

   assign s_ready  = (r_state == ST_IDLE);
   assign tx_bit   = r_tx_bit;
   assign tx_valid = r_tx_valid;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_fsm_pattern_transmitter.sv
// Self-checking bench: two transmitters (GAP=1 and GAP=0) share stimulus and are
// compared every cycle against a cycle-index model of the burst waveform.
module tb_fsm_pattern_transmitter;

   localparam int PAT_W = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             s_valid;
   logic [PAT_W-1:0] s_data;
   logic [CNT_W-1:0] s_reps;

   logic s_ready_g1, tx_bit_g1, tx_valid_g1, busy_g1, done_g1;
   logic s_ready_g0, tx_bit_g0, tx_valid_g0, busy_g0, done_g0;

   int n_vec = 0;
   int n_err = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   fsm_pattern_transmitter #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(1), .IDLE_BIT(1'b1)) dut_g1 (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_g1),
      .s_data(s_data), .s_reps(s_reps), .tx_bit(tx_bit_g1), .tx_valid(tx_valid_g1),
      .busy(busy_g1), .done(done_g1)
   );

   fsm_pattern_transmitter #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(0), .IDLE_BIT(1'b1)) dut_g0 (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_g0),
      .s_data(s_data), .s_reps(s_reps), .tx_bit(tx_bit_g0), .tx_valid(tx_valid_g0),
      .busy(busy_g0), .done(done_g0)
   );

   // Model: a burst is described only by cycles elapsed since its accept edge.
   typedef struct {
      logic             act;
      int               k;
      logic [PAT_W-1:0] data;
      int               reps;
   } mdl_t;

   mdl_t m_g1, m_g0;

   function automatic int burst_len(input int reps, input int gap);
      return (reps == 0) ? 0 : reps * PAT_W + (reps - 1) * gap;
   endfunction

   // Returns {s_ready, tx_valid, tx_bit, busy, done} for the current cycle.
   function automatic logic [4:0] expect_out(input mdl_t m, input int gap);
      int len, pos;
      if (!m.act) return 5'b10100;
      len = burst_len(m.reps, gap);
      if (m.k <= len) begin
         pos = (m.k - 1) % (PAT_W + gap);
         if (pos < PAT_W) return {1'b0, 1'b1, m.data[PAT_W-1-pos], 1'b1, 1'b0};
         return 5'b00110;
      end
      return 5'b10101;
   endfunction

   function automatic mdl_t step(input mdl_t m, input int gap, input logic rst,
                                 input logic v, input logic [PAT_W-1:0] d,
                                 input logic [CNT_W-1:0] r);
      logic [4:0] e;
      mdl_t n;
      e = expect_out(m, gap);
      n = m;
      if (rst) begin
         n.act = 1'b0;
      end else if (e[4] && v) begin
         n.act  = 1'b1;
         n.k    = 1;
         n.data = d;
         n.reps = int'(r);
      end else if (m.act) begin
         if (m.k >= burst_len(m.reps, gap) + 1) n.act = 1'b0;
         else n.k = m.k + 1;
      end
      return n;
   endfunction

   initial begin
      m_g1 = '{act: 1'b0, k: 0, data: '0, reps: 0};
      m_g0 = '{act: 1'b0, k: 0, data: '0, reps: 0};
   end

   always @(posedge clk) begin
      m_g1 = step(m_g1, 1, reset, s_valid, s_data, s_reps);
      m_g0 = step(m_g0, 0, reset, s_valid, s_data, s_reps);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("g1_outs", 32'({s_ready_g1, tx_valid_g1, tx_bit_g1, busy_g1, done_g1}),
               32'(expect_out(m_g1, 1)));
         check("g0_outs", 32'({s_ready_g0, tx_valid_g0, tx_bit_g0, busy_g0, done_g0}),
               32'(expect_out(m_g0, 0)));
      end
   end

   // Burst statistics used by the hand-computed literal checks.
   logic  mon_en = 1'b0;
   int    mb1, md1, mn1, mb0, md0, mn0;
   logic [31:0] ms1, ms0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (busy_g1) mb1++;
         if (done_g1) md1++;
         if (tx_valid_g1) begin ms1 = {ms1[30:0], tx_bit_g1}; mn1++; end
         if (busy_g0) mb0++;
         if (done_g0) md0++;
         if (tx_valid_g0) begin ms0 = {ms0[30:0], tx_bit_g0}; mn0++; end
      end
   end

   task automatic mon_clear();
      mb1 = 0; md1 = 0; mn1 = 0; ms1 = '0;
      mb0 = 0; md0 = 0; mn0 = 0; ms0 = '0;
      mon_en = 1'b1;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic wait_ready_g1();
      int t;
      t = 0;
      while (1) begin
         @(negedge clk);
         if (s_ready_g1) break;
         t++;
         if (t > 3000) begin
            check("ready_timeout", 32'(s_ready_g1), 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Holds the request until the GAP=1 instance accepts it; returns in burst cycle 1.
   task automatic send(input logic [PAT_W-1:0] d, input logic [CNT_W-1:0] r);
      s_data  = d;
      s_reps  = r;
      s_valid = 1'b1;
      wait_ready_g1();
      s_valid = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_reps  = '0;
      tick(1);
      cmp_en = 1'b1;
      tick(1);
      check("reset_outs", 32'({s_ready_g1, tx_valid_g1, tx_bit_g1, busy_g1, done_g1}), 32'b10100);
      reset = 1'b0;
      tick(1);

      // Single copy of 0101.
      mon_clear();
      send(4'b0101, 8'd1);
      tick(6);
      check("t1_stream", ms1, 32'b0101);
      check("t1_nbits", 32'(mn1), 32'd4);
      check("t1_busy", 32'(mb1), 32'd4);
      check("t1_done", 32'(md1), 32'd1);

      // Three copies with one gap cycle between them.
      mon_clear();
      send(4'b0101, 8'd3);
      tick(16);
      check("t2_stream", ms1, 32'b0101_0101_0101);
      check("t2_busy", 32'(mb1), 32'd14);
      check("t2_done", 32'(md1), 32'd1);
      check("t2_busy_g0", 32'(mb0), 32'd12);

      // Zero repeats: done pulse only.
      mon_clear();
      send(4'b1111, 8'd0);
      @(negedge clk);
      check("t3_done_ready", 32'({done_g1, s_ready_g1, tx_valid_g1}), 32'b110);
      tick(3);
      check("t3_nbits", 32'(mn1), 32'd0);
      check("t3_done", 32'(md1), 32'd1);

      // Second request held through the first burst with its data changing mid-burst.
      mon_clear();
      s_data  = 4'b0011;
      s_reps  = 8'd2;
      s_valid = 1'b1;
      wait_ready_g1();
      s_data  = 4'b1100;
      s_reps  = 8'd1;
      wait_ready_g1();
      s_valid = 1'b0;
      tick(8);
      check("t4_stream", ms1, 32'b0011_0011_1100);
      check("t4_busy", 32'(mb1), 32'd13);
      check("t4_done", 32'(md1), 32'd2);

      // Reset on the third bit of the second copy.
      mon_clear();
      send(4'b0101, 8'd3);
      tick(7);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      @(negedge clk);
      check("t5_after_reset", 32'({s_ready_g1, tx_valid_g1, tx_bit_g1, busy_g1, done_g1}), 32'b10100);
      tick(5);
      check("t5_stream", ms1, 32'b0101_010);
      check("t5_done", 32'(md1), 32'd0);
      mon_clear();
      send(4'b1001, 8'd1);
      tick(6);
      check("t5_new_stream", ms1, 32'b1001);
      check("t5_new_done", 32'(md1), 32'd1);

      // Back-to-back copies on the GAP=0 instance.
      apply_reset();
      mon_clear();
      send(4'b1010, 8'd2);
      tick(10);
      check("t6_stream_g0", ms0, 32'b1010_1010);
      check("t6_valid_g0", 32'(mn0), 32'd8);
      check("t6_busy_g0", 32'(mb0), 32'd8);

      // Maximum repeat count sends every copy.
      mon_clear();
      send(4'b0110, 8'd255);
      tick(1290);
      check("max_busy", 32'(mb1), 32'd1274);
      check("max_nbits", 32'(mn1), 32'd1020);
      check("max_done", 32'(md1), 32'd1);
      mon_en = 1'b0;

      // Random traffic, occasional zero counts and resets.
      for (int i = 0; i < 4000; i++) begin
         s_valid = ($urandom_range(0, 3) == 0);
         s_data  = PAT_W'($urandom);
         s_reps  = ($urandom_range(0, 7) == 0) ? 8'd0 : CNT_W'($urandom_range(1, 4));
         reset   = ($urandom_range(0, 399) == 0);
         tick(1);
      end
      reset   = 1'b0;
      s_valid = 1'b0;
      tick(40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
